// File: rtl/mznm_pkg.sv
// Shared constants for the mznm controller: opcodes, flag bit positions,
// memory geometry, reset/vector values and the ALU operation select.
package mznm_pkg;

  localparam int IMEM_WORDS = 1024;
  localparam int DMEM_WORDS = 2048;

  localparam logic [15:0] INT_VECTOR = 16'h0100;
  localparam logic [10:0] SP_RESET   = 11'(DMEM_WORDS - 1);

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_SETC = 5'b00001;
  localparam logic [4:0] OP_CLRC = 5'b00010;
  localparam logic [4:0] OP_MOV  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_SUB  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_PUSH = 5'b01010;
  localparam logic [4:0] OP_POP  = 5'b01011;
  localparam logic [4:0] OP_LDM  = 5'b01100;
  localparam logic [4:0] OP_LDD  = 5'b01101;
  localparam logic [4:0] OP_STD  = 5'b01110;
  localparam logic [4:0] OP_JZ   = 5'b10000;
  localparam logic [4:0] OP_JN   = 5'b10001;
  localparam logic [4:0] OP_JMP  = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;
  localparam logic [4:0] OP_RTI  = 5'b10101;
  localparam logic [4:0] OP_NOT  = 5'b11010;
  localparam logic [4:0] OP_INC  = 5'b11011;
  localparam logic [4:0] OP_DEC  = 5'b11100;
  localparam logic [4:0] OP_OUT  = 5'b11101;
  localparam logic [4:0] OP_IN   = 5'b11110;

  typedef enum logic [2:0] {
    ALU_PASS,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_NOT,
    ALU_INC,
    ALU_DEC
  } alu_op_e;

endpackage

// File: rtl/mznm_alu.sv
// Combinational 16-bit ALU; carry passes through unchanged for the logic ops.
module mznm_alu
  import mznm_pkg::*;
(
  input  alu_op_e     op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] result,
  output logic        z,
  output logic        n,
  output logic        c
);

  logic [16:0] sum;

  always_comb begin
    sum    = '0;
    result = a;
    c      = cin;
    case (op)
      ALU_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[15:0];
        c      = sum[16];
      end
      ALU_SUB: begin
        result = a - b;
        c      = (a < b);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOT: result = ~a;
      ALU_INC: begin
        sum    = {1'b0, a} + 17'd1;
        result = sum[15:0];
        c      = sum[16];
      end
      ALU_DEC: begin
        result = a - 16'd1;
        c      = (a == 16'h0000);
      end
      default: result = a;
    endcase
    z = (result == 16'h0000);
    n = result[15];
  end

endmodule

// File: rtl/mznm_controller.sv
// Single-cycle 16-bit controller with stack, port I/O and one edge-triggered
// interrupt; the imem_wr_* port loads the program image.
module mznm_controller
  import mznm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        interruptSignal,
  input  logic [15:0] inPortData,
  output logic [15:0] outPortData,
  output logic        outSignalEn,
  input  logic        imem_wr_en,
  input  logic [9:0]  imem_wr_addr,
  input  logic [15:0] imem_wr_data
);

  logic [15:0] imem_mem [0:IMEM_WORDS-1];
  logic [15:0] dmem_mem [0:DMEM_WORDS-1];
  logic [15:0] regs_q   [0:7];

  logic [15:0] pc_q, pc_d;
  logic [10:0] sp_q, sp_d;
  logic [2:0]  flags_q, flags_d;
  logic [2:0]  shadow_q, shadow_d;
  logic        pending_q, pending_d;
  logic        in_isr_q, in_isr_d;
  logic        int_prev_q;
  logic [15:0] out_data_q, out_data_d;
  logic        out_en_q, out_en_d;

  logic [4:0]  opcode;
  logic [2:0]  ra_idx, rb_idx;
  logic [15:0] reg_a, reg_b, imem_next, stack_top, dmem_rd;
  logic [10:0] sp_inc;
  logic        int_edge;

  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        dm_we;
  logic [10:0] dm_waddr;
  logic [15:0] dm_wdata;

  alu_op_e     alu_op;
  logic [15:0] alu_res;
  logic        alu_z, alu_n, alu_c;

  assign opcode    = imem_mem[pc_q[9:0]][15:11];
  assign ra_idx    = imem_mem[pc_q[9:0]][10:8];
  assign rb_idx    = imem_mem[pc_q[9:0]][7:5];
  assign imem_next = imem_mem[pc_q[9:0] + 10'd1];
  assign reg_a     = regs_q[ra_idx];
  assign reg_b     = regs_q[rb_idx];
  assign sp_inc    = sp_q + 11'd1;
  assign stack_top = dmem_mem[sp_inc];
  assign dmem_rd   = dmem_mem[reg_b[10:0]];
  assign int_edge  = interruptSignal & ~int_prev_q;

  mznm_alu u_alu (
    .op     (alu_op),
    .a      (reg_a),
    .b      (reg_b),
    .cin    (flags_q[FLAG_C]),
    .result (alu_res),
    .z      (alu_z),
    .n      (alu_n),
    .c      (alu_c)
  );

  always_comb begin
    pc_d       = pc_q + 16'd1;
    sp_d       = sp_q;
    flags_d    = flags_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q | int_edge;
    in_isr_d   = in_isr_q;
    out_data_d = out_data_q;
    out_en_d   = 1'b0;
    rf_we      = 1'b0;
    rf_waddr   = ra_idx;
    rf_wdata   = alu_res;
    dm_we      = 1'b0;
    dm_waddr   = sp_q;
    dm_wdata   = reg_b;
    alu_op     = ALU_PASS;

    if (pending_q && !in_isr_q) begin
      // Interrupt entry replaces the instruction: the current PC is the return address.
      pc_d      = INT_VECTOR;
      dm_we     = 1'b1;
      dm_wdata  = pc_q;
      sp_d      = sp_q - 11'd1;
      shadow_d  = flags_q;
      in_isr_d  = 1'b1;
      pending_d = int_edge;
    end else begin
      case (opcode)
        OP_SETC: flags_d[FLAG_C] = 1'b1;
        OP_CLRC: flags_d[FLAG_C] = 1'b0;
        OP_MOV: begin
          rf_we    = 1'b1;
          rf_wdata = reg_b;
        end
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_INC, OP_DEC: begin
          case (opcode)
            OP_ADD:  alu_op = ALU_ADD;
            OP_SUB:  alu_op = ALU_SUB;
            OP_AND:  alu_op = ALU_AND;
            OP_OR:   alu_op = ALU_OR;
            OP_NOT:  alu_op = ALU_NOT;
            OP_INC:  alu_op = ALU_INC;
            default: alu_op = ALU_DEC;
          endcase
          rf_we           = 1'b1;
          flags_d[FLAG_Z] = alu_z;
          flags_d[FLAG_N] = alu_n;
          flags_d[FLAG_C] = alu_c;
        end
        OP_PUSH: begin
          dm_we = 1'b1;
          sp_d  = sp_q - 11'd1;
        end
        OP_POP: begin
          rf_we    = 1'b1;
          rf_wdata = stack_top;
          sp_d     = sp_inc;
        end
        OP_LDM: begin
          rf_we    = 1'b1;
          rf_wdata = imem_next;
          pc_d     = pc_q + 16'd2;
        end
        OP_LDD: begin
          rf_we    = 1'b1;
          rf_wdata = dmem_rd;
        end
        OP_STD: begin
          dm_we    = 1'b1;
          dm_waddr = reg_b[10:0];
          dm_wdata = reg_a;
        end
        OP_JZ: if (flags_q[FLAG_Z]) begin
          pc_d            = reg_a;
          flags_d[FLAG_Z] = 1'b0;
        end
        OP_JN: if (flags_q[FLAG_N]) begin
          pc_d            = reg_a;
          flags_d[FLAG_N] = 1'b0;
        end
        OP_JMP: pc_d = reg_a;
        OP_CALL: begin
          dm_we    = 1'b1;
          dm_wdata = pc_q + 16'd1;
          sp_d     = sp_q - 11'd1;
          pc_d     = reg_a;
        end
        OP_RET: begin
          pc_d = stack_top;
          sp_d = sp_inc;
        end
        OP_RTI: begin
          pc_d     = stack_top;
          sp_d     = sp_inc;
          flags_d  = shadow_q;
          in_isr_d = 1'b0;
        end
        OP_OUT: begin
          out_data_d = reg_a;
          out_en_d   = 1'b1;
        end
        OP_IN: begin
          rf_we    = 1'b1;
          rf_wdata = inPortData;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= 16'h0000;
      sp_q       <= SP_RESET;
      flags_q    <= 3'b000;
      shadow_q   <= 3'b000;
      pending_q  <= 1'b0;
      in_isr_q   <= 1'b0;
      out_data_q <= 16'h0000;
      out_en_q   <= 1'b0;
      // A level already high when reset releases is not an edge.
      int_prev_q <= interruptSignal;
      for (int i = 0; i < 8; i++) regs_q[i] <= 16'h0000;
    end else begin
      pc_q       <= pc_d;
      sp_q       <= sp_d;
      flags_q    <= flags_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      in_isr_q   <= in_isr_d;
      out_data_q <= out_data_d;
      out_en_q   <= out_en_d;
      int_prev_q <= interruptSignal;
      if (rf_we) regs_q[rf_waddr] <= rf_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (dm_we && !reset) dmem_mem[dm_waddr] <= dm_wdata;
  end

  always_ff @(posedge clk) begin
    if (imem_wr_en) imem_mem[imem_wr_addr] <= imem_wr_data;
  end

  assign outPortData = out_data_q;
  assign outSignalEn = out_en_q;

endmodule

// File: tb/tb_mznm_controller.sv
// Directed bench: loads a small program, single-steps it and checks
// architectural state after every instruction or interrupt entry.
module tb_mznm_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        interruptSignal;
  logic [15:0] inPortData;
  logic [15:0] outPortData;
  logic        outSignalEn;
  logic        imem_wr_en;
  logic [9:0]  imem_wr_addr;
  logic [15:0] imem_wr_data;

  int checks = 0;
  int errors = 0;
  logic [15:0] prog [0:1023];

  mznm_controller dut (
    .clk             (clk),
    .reset           (reset),
    .interruptSignal (interruptSignal),
    .inPortData      (inPortData),
    .outPortData     (outPortData),
    .outSignalEn     (outSignalEn),
    .imem_wr_en      (imem_wr_en),
    .imem_wr_addr    (imem_wr_addr),
    .imem_wr_data    (imem_wr_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] enc(input logic [4:0] op, input int a, input int b);
    logic [2:0] a3, b3;
    a3 = a[2:0];
    b3 = b[2:0];
    return {op, a3, b3, 5'b00000};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_program();
    for (int i = 0; i < 1024; i++) prog[i] = 16'h0000;
    prog[0]  = enc(5'b11010, 0, 0);  // NOT R0
    prog[1]  = enc(5'b11010, 1, 0);  // NOT R1
    prog[2]  = enc(5'b01010, 0, 1);  // PUSH R1
    prog[3]  = enc(5'b00100, 1, 0);  // ADD R1,R0
    prog[4]  = enc(5'b01100, 5, 0);  // LDM R5
    prog[5]  = 16'h0006;
    prog[6]  = enc(5'b01100, 6, 0);  // LDM R6
    prog[7]  = 16'h0002;
    prog[8]  = enc(5'b00101, 5, 6);  // SUB R5,R6
    prog[9]  = enc(5'b01011, 7, 0);  // POP R7
    prog[10] = enc(5'b11110, 2, 0);  // IN R2
    prog[11] = enc(5'b11101, 2, 0);  // OUT R2
    prog[12] = enc(5'b01100, 4, 0);  // LDM R4
    prog[13] = 16'h0034;
    prog[14] = enc(5'b10011, 4, 0);  // CALL R4
    prog[15] = enc(5'b11011, 0, 0);  // INC R0
    prog[16] = enc(5'b11100, 0, 0);  // DEC R0
    prog[17] = enc(5'b10000, 4, 0);  // JZ R4
    prog[18] = enc(5'b01100, 3, 0);  // LDM R3
    prog[19] = 16'h0016;
    prog[20] = enc(5'b10001, 3, 0);  // JN R3
    prog[22] = enc(5'b00011, 1, 5);  // MOV R1,R5
    prog[23] = enc(5'b01110, 1, 6);  // STD R1,[R6]
    prog[24] = enc(5'b01101, 3, 6);  // LDD R3,[R6]
    prog[25] = enc(5'b11111, 7, 7);  // unlisted opcode
    prog[16'h34]  = enc(5'b10100, 0, 0);  // RET
    prog[16'h100] = enc(5'b00010, 0, 0);  // CLRC
    prog[16'h101] = enc(5'b11010, 0, 0);  // NOT R0
    prog[16'h102] = enc(5'b10101, 0, 0);  // RTI
    reset = 1'b1;
    interruptSignal = 1'b0;
    inPortData = 16'h0000;
    for (int i = 0; i < 1024; i++) begin
      imem_wr_en   = 1'b1;
      imem_wr_addr = i[9:0];
      imem_wr_data = prog[i];
      step();
    end
    imem_wr_en = 1'b0;
    step();
  endtask

  task automatic test_reset();
    checks++; if (dut.pc_q !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h want 0000", dut.pc_q); end
    checks++; if (dut.sp_q !== 11'd2047) begin errors++; $display("FAIL reset_sp got %0d want 2047", dut.sp_q); end
    checks++; if (dut.flags_q !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", dut.flags_q); end
    checks++; if (dut.regs_q[0] !== 16'h0000) begin errors++; $display("FAIL reset_r0 got %h want 0000", dut.regs_q[0]); end
    checks++; if (outPortData !== 16'h0000 || outSignalEn !== 1'b0) begin errors++; $display("FAIL reset_out got %h/%b want 0000/0", outPortData, outSignalEn); end
    reset = 1'b0;
  endtask

  task automatic test_not();
    step(); step();
    checks++; if (dut.regs_q[0] !== 16'hFFFF || dut.regs_q[1] !== 16'hFFFF) begin errors++; $display("FAIL not_regs got %h %h want FFFF FFFF", dut.regs_q[0], dut.regs_q[1]); end
    checks++; if (dut.flags_q !== 3'b010) begin errors++; $display("FAIL not_flags got %b want 010", dut.flags_q); end
  endtask

  task automatic test_push_add();
    step();
    checks++; if (dut.dmem_mem[2047] !== 16'hFFFF || dut.sp_q !== 11'd2046) begin errors++; $display("FAIL push got M=%h SP=%0d want FFFF 2046", dut.dmem_mem[2047], dut.sp_q); end
    step();
    checks++; if (dut.regs_q[1] !== 16'hFFFE) begin errors++; $display("FAIL add_r1 got %h want FFFE", dut.regs_q[1]); end
    checks++; if (dut.flags_q !== 3'b110) begin errors++; $display("FAIL add_flags got %b want 110", dut.flags_q); end
  endtask

  task automatic test_ldm_sub_pop();
    step();
    checks++; if (dut.pc_q !== 16'h0006 || dut.regs_q[5] !== 16'h0006) begin errors++; $display("FAIL ldm1 got PC=%h R5=%h want 0006 0006", dut.pc_q, dut.regs_q[5]); end
    step();
    checks++; if (dut.pc_q !== 16'h0008 || dut.regs_q[6] !== 16'h0002) begin errors++; $display("FAIL ldm2 got PC=%h R6=%h want 0008 0002", dut.pc_q, dut.regs_q[6]); end
    step();
    checks++; if (dut.regs_q[5] !== 16'h0004 || dut.flags_q !== 3'b000) begin errors++; $display("FAIL sub got R5=%h F=%b want 0004 000", dut.regs_q[5], dut.flags_q); end
    step();
    checks++; if (dut.regs_q[7] !== 16'hFFFF || dut.sp_q !== 11'd2047) begin errors++; $display("FAIL pop got R7=%h SP=%0d want FFFF 2047", dut.regs_q[7], dut.sp_q); end
  endtask

  task automatic test_io();
    inPortData = 16'h0019;
    step();
    inPortData = 16'h0000;
    checks++; if (dut.regs_q[2] !== 16'h0019) begin errors++; $display("FAIL in_r2 got %h want 0019", dut.regs_q[2]); end
    checks++; if (outSignalEn !== 1'b0) begin errors++; $display("FAIL out_idle got %b want 0", outSignalEn); end
    step();
    checks++; if (outPortData !== 16'h0019 || outSignalEn !== 1'b1) begin errors++; $display("FAIL out_strobe got %h/%b want 0019/1", outPortData, outSignalEn); end
    step();
    checks++; if (outPortData !== 16'h0019 || outSignalEn !== 1'b0) begin errors++; $display("FAIL out_hold got %h/%b want 0019/0", outPortData, outSignalEn); end
  endtask

  task automatic test_call_ret();
    checks++; if (dut.pc_q !== 16'h000E || dut.regs_q[4] !== 16'h0034) begin errors++; $display("FAIL ldm_r4 got PC=%h R4=%h want 000E 0034", dut.pc_q, dut.regs_q[4]); end
    step();
    checks++; if (dut.pc_q !== 16'h0034 || dut.dmem_mem[2047] !== 16'h000F || dut.sp_q !== 11'd2046) begin errors++; $display("FAIL call got PC=%h M=%h SP=%0d want 0034 000F 2046", dut.pc_q, dut.dmem_mem[2047], dut.sp_q); end
    step();
    checks++; if (dut.pc_q !== 16'h000F || dut.sp_q !== 11'd2047) begin errors++; $display("FAIL ret got PC=%h SP=%0d want 000F 2047", dut.pc_q, dut.sp_q); end
  endtask

  task automatic test_wrap();
    step();
    checks++; if (dut.regs_q[0] !== 16'h0000 || dut.flags_q !== 3'b101) begin errors++; $display("FAIL inc_wrap got R0=%h F=%b want 0000 101", dut.regs_q[0], dut.flags_q); end
    step();
    checks++; if (dut.regs_q[0] !== 16'hFFFF || dut.flags_q !== 3'b110) begin errors++; $display("FAIL dec_wrap got R0=%h F=%b want FFFF 110", dut.regs_q[0], dut.flags_q); end
  endtask

  task automatic test_jumps();
    step();
    checks++; if (dut.pc_q !== 16'h0012) begin errors++; $display("FAIL jz_not_taken got PC=%h want 0012", dut.pc_q); end
    step();
    step();
    checks++; if (dut.pc_q !== 16'h0016 || dut.flags_q !== 3'b100) begin errors++; $display("FAIL jn_taken got PC=%h F=%b want 0016 100", dut.pc_q, dut.flags_q); end
  endtask

  task automatic test_mem();
    step();
    checks++; if (dut.regs_q[1] !== 16'h0004) begin errors++; $display("FAIL mov got %h want 0004", dut.regs_q[1]); end
    step();
    checks++; if (dut.dmem_mem[2] !== 16'h0004) begin errors++; $display("FAIL std got %h want 0004", dut.dmem_mem[2]); end
    step();
    checks++; if (dut.regs_q[3] !== 16'h0004) begin errors++; $display("FAIL ldd got %h want 0004", dut.regs_q[3]); end
    step();
    checks++; if (dut.pc_q !== 16'h001A || dut.flags_q !== 3'b100 || dut.regs_q[7] !== 16'hFFFF) begin errors++; $display("FAIL unlisted_nop got PC=%h F=%b R7=%h want 001A 100 FFFF", dut.pc_q, dut.flags_q, dut.regs_q[7]); end
  endtask

  task automatic test_interrupt();
    interruptSignal = 1'b1;
    step();
    checks++; if (dut.pc_q !== 16'h001B) begin errors++; $display("FAIL int_insn_completes got PC=%h want 001B", dut.pc_q); end
    step();
    checks++; if (dut.pc_q !== 16'h0100 || dut.dmem_mem[2047] !== 16'h001B || dut.sp_q !== 11'd2046) begin errors++; $display("FAIL int_entry got PC=%h M=%h SP=%0d want 0100 001B 2046", dut.pc_q, dut.dmem_mem[2047], dut.sp_q); end
    interruptSignal = 1'b0;
    step();
    checks++; if (dut.flags_q !== 3'b000) begin errors++; $display("FAIL isr_clrc got F=%b want 000", dut.flags_q); end
    interruptSignal = 1'b1;
    step();
    checks++; if (dut.pc_q !== 16'h0102 || dut.flags_q !== 3'b001) begin errors++; $display("FAIL isr_nested_blocked got PC=%h F=%b want 0102 001", dut.pc_q, dut.flags_q); end
    step();
    checks++; if (dut.pc_q !== 16'h001B || dut.flags_q !== 3'b100 || dut.sp_q !== 11'd2047) begin errors++; $display("FAIL rti got PC=%h F=%b SP=%0d want 001B 100 2047", dut.pc_q, dut.flags_q, dut.sp_q); end
    step();
    checks++; if (dut.pc_q !== 16'h0100 || dut.dmem_mem[2047] !== 16'h001B) begin errors++; $display("FAIL int_second got PC=%h M=%h want 0100 001B", dut.pc_q, dut.dmem_mem[2047]); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    step();
    checks++; if (dut.pc_q !== 16'h0000 || dut.sp_q !== 11'd2047 || dut.in_isr_q !== 1'b0) begin errors++; $display("FAIL mid_reset got PC=%h SP=%0d ISR=%b want 0000 2047 0", dut.pc_q, dut.sp_q, dut.in_isr_q); end
    checks++; if (dut.regs_q[0] !== 16'h0000 || dut.regs_q[7] !== 16'h0000 || dut.flags_q !== 3'b000) begin errors++; $display("FAIL mid_reset_regs got R0=%h R7=%h F=%b want 0000 0000 000", dut.regs_q[0], dut.regs_q[7], dut.flags_q); end
    reset = 1'b0;
  endtask

  initial begin
    load_program();
    test_reset();
    test_not();
    test_push_add();
    test_ldm_sub_pop();
    test_io();
    test_call_ret();
    test_wrap();
    test_jumps();
    test_mem();
    test_interrupt();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
